mmio_port_timer: RTL and testbench
==================================

// Module: mmio_port_timer
// PURPOSE
//  Memory-mapped I/O responder on the processor's MEM-stage data bus: the target end of the
//  load/store interface the MIPS core drives (Address, WriteData, MemWrite, MemRead -> ReadData).
//  Owns the board I/O: drives PortOut, synchronises PortIn with edge capture, and hosts a
//  compare timer. Sits beside DataMemory; top level muxes ReadData on Hit.
// PARAMETERS
//  BASE_ADDR   32'h1001_0400  byte base of 7-word register window
//  IN_WIDTH    8              PortIn width (zero-extended on read)
// PORTS
//  clk        in   1         system clock
//  reset      in   1         synchronous, active-high reset
//  Address    in   32        byte address from EX/MEM ALU result
//  WriteData  in   32        store data (forwarded rt)
//  MemWrite   in   1         store strobe, MEM stage
//  MemRead    in   1         load strobe, MEM stage
//  ReadData   out  32        load data, combinational
//  Hit        out  1         Address decodes to this block
//  PortIn     in   IN_WIDTH  asynchronous external inputs
//  PortOut    out  32        PORT_OUT register
//  Event      out  1         (EDGE_STATUS!=0) | MATCH flag
// BEHAVIOUR
//  - One clock, synchronous active-high reset; all state updates on rising clk.
//  - Map (offset): 0x00 PORT_OUT RW; 0x04 PORT_IN RO; 0x08 EDGE_STATUS W1C; 0x0C TIMER_COUNT RW;
//    0x10 TIMER_CMP RW; 0x14 CTRL RW [0]=timer enable,[1]=clear-on-match; 0x18 STATUS W1C [0]=MATCH.
//  - Hit=1 iff BASE_ADDR<=Address<BASE_ADDR+0x1C and Address[1:0]==0; unaligned/out-of-range -> Hit=0,
//    no side effect. Unused register bits read 0, writes ignored.
//  - Write: MemWrite&Hit commits at next edge. MemRead&MemWrite both set: write performed,
//    ReadData returns pre-write value.
//  - Read: ReadData = selected reg when MemRead&Hit, else 32'h0. Zero-latency (same cycle as
//    MEM stage). Reads have no side effects.
//  - PortIn: 2-flop synchroniser (s1,s2) + history flop s3. PORT_IN = s2, visible 2 edges after
//    input change. EDGE_STATUS[i] set at the edge where s2[i]&~s3[i] (3rd edge after rise).
//  - EDGE/STATUS W1C: written 1 bits clear; hardware set in the same cycle wins over clear.
//  - Timer (CTRL[0]=1): TIMER_COUNT+1 each cycle, wraps 32'hFFFF_FFFF->0. When COUNT==CMP:
//    MATCH set next edge; if CTRL[1], COUNT loads 0 at that edge instead of incrementing.
//    Software write to TIMER_COUNT overrides increment/clear that cycle. CTRL[0]=0: COUNT holds.
//  - Match compared on current COUNT every enabled cycle; CMP write takes effect next cycle.
//  - Reset: PORT_OUT, sync flops, EDGE_STATUS, COUNT, CMP, CTRL, MATCH = 0; hence PortOut=0,
//    Event=0, ReadData=0. Reset mid-count discards count; reset dominates any write same cycle.
// CONFIGURATION
//  MMIO_TIMER_EN defined: timer, CTRL, STATUS.MATCH present as above.
//  Not defined: offsets 0x0C-0x18 still Hit, read 0, writes ignored; Event = (EDGE_STATUS!=0);
//  no timer flops synthesised.
// TESTING
//  1 Reset held 2 cycles, then idle -> PortOut=0, Event=0, ReadData=0, Hit=0 at Address=0.
//  2 SW BASE+0x00 <- 32'hDEAD_BEEF; LW BASE+0x00 -> PortOut & ReadData = 32'hDEAD_BEEF next cycle.
//  3 PortIn 8'h00->8'h05 at cycle t -> PORT_IN=32'h5 from t+2; EDGE_STATUS=32'h5, Event=1 from t+3;
//    SW 0x08 <- 32'h1 -> EDGE_STATUS=32'h4; clear in same cycle as new rise on bit0 -> bit0 stays 1.
//  4 (MMIO_TIMER_EN) CMP=5, CTRL=3 -> COUNT 0..5, MATCH=1, COUNT=0 following edge, repeats;
//    SW 0x18 <- 1 clears MATCH, Event=0 if EDGE_STATUS=0.
//  5 (MMIO_TIMER_EN) COUNT=32'hFFFF_FFFE, CTRL=1, CMP=0 -> FFFF_FFFF, 0, MATCH set; wrap no stall.
//  6 Address BASE+0x02 and BASE+0x1C with MemWrite -> Hit=0, no register changes.

Source files
------------

// File: rtl/mmio_port_timer.sv
// MMIO responder: output port, synchronised input port with rise capture, compare timer.
// Define MMIO_TIMER_EN to build the timer, CTRL and STATUS.MATCH registers.
module mmio_port_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0400,
  parameter int          IN_WIDTH  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Address,
  input  logic [31:0]         WriteData,
  input  logic                MemWrite,
  input  logic                MemRead,
  output logic [31:0]         ReadData,
  output logic                Hit,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         PortOut,
  output logic                Event
);

  logic [31:0]         off;
  logic [2:0]          sel;
  logic                we;
  logic [31:0]         port_out_q, port_out_d;
  logic [IN_WIDTH-1:0] s1_q, s2_q, s3_q;
  logic [IN_WIDTH-1:0] edge_q, edge_d;
  logic [31:0]         rd_mux;

  // Addresses below the base wrap to a large offset and fail the range test.
  always_comb begin
    off = Address - BASE_ADDR;
    sel = off[4:2];
    Hit = (off < 32'h1C) && (Address[1:0] == 2'b00);
    we  = MemWrite && Hit;
  end

  always_comb begin
    port_out_d = port_out_q;
    if (we && sel == 3'd0) port_out_d = WriteData;
    edge_d = edge_q;
    if (we && sel == 3'd2) edge_d = edge_q & ~WriteData[IN_WIDTH-1:0];
    edge_d = edge_d | (s2_q & ~s3_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      port_out_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      edge_q     <= '0;
    end else begin
      port_out_q <= port_out_d;
      s1_q       <= PortIn;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      edge_q     <= edge_d;
    end
  end

`ifdef MMIO_TIMER_EN
  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q, cmp_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        match_q, match_d;
  logic        at_cmp;

  always_comb begin
    at_cmp  = (count_q == cmp_q);
    count_d = count_q;
    cmp_d   = cmp_q;
    ctrl_d  = ctrl_q;
    if (we && sel == 3'd3) count_d = WriteData;
    else if (ctrl_q[0]) count_d = (at_cmp && ctrl_q[1]) ? 32'h0 : count_q + 32'h1;
    if (we && sel == 3'd4) cmp_d = WriteData;
    if (we && sel == 3'd5) ctrl_d = WriteData[1:0];
    match_d = match_q;
    if (we && sel == 3'd6 && WriteData[0]) match_d = 1'b0;
    if (ctrl_q[0] && at_cmp) match_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      cmp_q   <= '0;
      ctrl_q  <= '0;
      match_q <= 1'b0;
    end else begin
      count_q <= count_d;
      cmp_q   <= cmp_d;
      ctrl_q  <= ctrl_d;
      match_q <= match_d;
    end
  end

  assign Event = (|edge_q) | match_q;
`else
  assign Event = |edge_q;
`endif

  always_comb begin
    rd_mux = 32'h0;
    case (sel)
      3'd0: rd_mux = port_out_q;
      3'd1: rd_mux = 32'(s2_q);
      3'd2: rd_mux = 32'(edge_q);
`ifdef MMIO_TIMER_EN
      3'd3: rd_mux = count_q;
      3'd4: rd_mux = cmp_q;
      3'd5: rd_mux = {30'h0, ctrl_q};
      3'd6: rd_mux = {31'h0, match_q};
`endif
      default: rd_mux = 32'h0;
    endcase
    ReadData = (MemRead && Hit) ? rd_mux : 32'h0;
  end

  assign PortOut = port_out_q;

endmodule

// File: tb/tb_mmio_port_timer.sv
// Directed bench for mmio_port_timer: bus vector table plus edge and timer sequences.
// Timer sequences run only when MMIO_TIMER_EN is defined.
module tb_mmio_port_timer;

  localparam logic [31:0] BASE = 32'h1001_0400;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address, WriteData, ReadData, PortOut;
  logic        MemWrite, MemRead, Hit, Event;
  logic [7:0]  PortIn;

  int checks = 0;
  int failures = 0;

  mmio_port_timer #(.BASE_ADDR(BASE), .IN_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData), .Hit(Hit),
    .PortIn(PortIn), .PortOut(PortOut), .Event(Event)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_hit;
    logic [31:0] exp_rd;
    logic [31:0] exp_po;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    Address = a;
    WriteData = d;
    MemWrite = 1'b1;
    tick();
    MemWrite = 1'b0;
    Address = 32'h0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    Address = a;
    MemRead = 1'b1;
    #1;
    d = ReadData;
    MemRead = 1'b0;
    Address = 32'h0;
    #1;
  endtask

  logic [31:0] r;

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 32'h0,        32'h0,         1'b0, 32'h0,         32'h0};
    vecs[1]  = '{1'b1, 1'b0, BASE,         32'hDEAD_BEEF, 1'b1, 32'h0,         32'h0};
    vecs[2]  = '{1'b0, 1'b1, BASE,         32'h0,         1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b1, 1'b1, BASE,         32'h1234_5678, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b0, 1'b1, BASE,         32'h0,         1'b1, 32'h1234_5678, 32'h1234_5678};
    vecs[5]  = '{1'b1, 1'b0, BASE + 32'h2, 32'h0,         1'b0, 32'h0,         32'h1234_5678};
    vecs[6]  = '{1'b1, 1'b0, BASE + 32'h1C, 32'h0,        1'b0, 32'h0,         32'h1234_5678};
    vecs[7]  = '{1'b0, 1'b1, BASE + 32'h1C, 32'h0,        1'b0, 32'h0,         32'h1234_5678};
    vecs[8]  = '{1'b0, 1'b1, BASE,         32'h0,         1'b1, 32'h1234_5678, 32'h1234_5678};
    vecs[9]  = '{1'b0, 1'b1, BASE + 32'h4, 32'h0,         1'b1, 32'h0,         32'h1234_5678};
    vecs[10] = '{1'b0, 1'b1, BASE - 32'h4, 32'h0,         1'b0, 32'h0,         32'h1234_5678};
    vecs[11] = '{1'b0, 1'b1, BASE + 32'h14, 32'h0,        1'b1, 32'h0,         32'h1234_5678};
    vecs[12] = '{1'b0, 1'b0, BASE + 32'h0C, 32'h0,        1'b1, 32'h0,         32'h1234_5678};

    reset = 1'b1;
    Address = 32'h0;
    WriteData = 32'h0;
    MemWrite = 1'b0;
    MemRead = 1'b0;
    PortIn = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("reset_portout", PortOut, 32'h0);
    chk("reset_event", {31'h0, Event}, 32'h0);
    chk("reset_readdata", ReadData, 32'h0);
    chk("reset_hit", {31'h0, Hit}, 32'h0);

    for (int i = 0; i < 13; i++) begin
      Address = vecs[i].addr;
      WriteData = vecs[i].wdata;
      MemWrite = vecs[i].we;
      MemRead = vecs[i].re;
      #1;
      chk($sformatf("vec%0d_hit", i), {31'h0, Hit}, {31'h0, vecs[i].exp_hit});
      chk($sformatf("vec%0d_rd", i), ReadData, vecs[i].exp_rd);
      chk($sformatf("vec%0d_po", i), PortOut, vecs[i].exp_po);
      tick();
    end
    MemWrite = 1'b0;
    MemRead = 1'b0;
    Address = 32'h0;
    #1;

    // input synchroniser latency and rise capture
    PortIn = 8'h05;
    tick();
    bus_rd(BASE + 32'h4, r);
    chk("portin_edge1", r, 32'h0);
    tick();
    bus_rd(BASE + 32'h4, r);
    chk("portin_edge2", r, 32'h5);
    bus_rd(BASE + 32'h8, r);
    chk("edge_edge2", r, 32'h0);
    chk("event_edge2", {31'h0, Event}, 32'h0);
    tick();
    bus_rd(BASE + 32'h8, r);
    chk("edge_edge3", r, 32'h5);
    chk("event_edge3", {31'h0, Event}, 32'h1);
    bus_wr(BASE + 32'h8, 32'h1);
    bus_rd(BASE + 32'h8, r);
    chk("edge_w1c", r, 32'h4);

    // clear colliding with a fresh rise on bit 0
    PortIn = 8'h04;
    repeat (4) tick();
    PortIn = 8'h05;
    tick();
    tick();
    bus_wr(BASE + 32'h8, 32'h5);
    bus_rd(BASE + 32'h8, r);
    chk("edge_set_wins", r, 32'h1);
    bus_wr(BASE + 32'h8, 32'h1);
    bus_rd(BASE + 32'h8, r);
    chk("edge_cleared", r, 32'h0);
    chk("event_cleared", {31'h0, Event}, 32'h0);

`ifdef MMIO_TIMER_EN
    bus_wr(BASE + 32'h10, 32'h5);
    bus_wr(BASE + 32'h14, 32'h3);
    for (int i = 0; i <= 5; i++) begin
      bus_rd(BASE + 32'hC, r);
      chk($sformatf("count_%0d", i), r, 32'(i));
      bus_rd(BASE + 32'h18, r);
      chk($sformatf("match_pre_%0d", i), r, 32'h0);
      if (i < 5) tick();
    end
    tick();
    bus_rd(BASE + 32'hC, r);
    chk("count_cleared", r, 32'h0);
    bus_rd(BASE + 32'h18, r);
    chk("match_set", r, 32'h1);
    chk("event_match", {31'h0, Event}, 32'h1);
    bus_wr(BASE + 32'h18, 32'h1);
    bus_rd(BASE + 32'h18, r);
    chk("match_w1c", r, 32'h0);
    chk("event_after_w1c", {31'h0, Event}, 32'h0);
    bus_rd(BASE + 32'hC, r);
    chk("count_after_w1c", r, 32'h1);
    bus_wr(BASE + 32'h14, 32'h0);
    tick();
    bus_rd(BASE + 32'hC, r);
    chk("count_hold", r, 32'h2);

    bus_wr(BASE + 32'hC, 32'hFFFF_FFFE);
    bus_wr(BASE + 32'h10, 32'h0);
    bus_wr(BASE + 32'h14, 32'h1);
    bus_rd(BASE + 32'hC, r);
    chk("wrap_start", r, 32'hFFFF_FFFE);
    tick();
    bus_rd(BASE + 32'hC, r);
    chk("wrap_max", r, 32'hFFFF_FFFF);
    tick();
    bus_rd(BASE + 32'hC, r);
    chk("wrap_zero", r, 32'h0);
    bus_rd(BASE + 32'h18, r);
    chk("wrap_nomatch", r, 32'h0);
    tick();
    bus_rd(BASE + 32'hC, r);
    chk("wrap_one", r, 32'h1);
    bus_rd(BASE + 32'h18, r);
    chk("wrap_match", r, 32'h1);
`endif

    // reset mid-operation dominates a same-cycle write
    Address = BASE;
    WriteData = 32'hFFFF_0000;
    MemWrite = 1'b1;
    reset = 1'b1;
    tick();
    MemWrite = 1'b0;
    reset = 1'b0;
    Address = 32'h0;
    #1;
    chk("rst2_portout", PortOut, 32'h0);
    chk("rst2_event", {31'h0, Event}, 32'h0);
    bus_rd(BASE + 32'hC, r);
    chk("rst2_count", r, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
